i2s_receiver: RTL and testbench
===============================

# i2s_receiver

- Deserialises the I2S2 ADC serial stream into signed parallel samples tagged left or right.
- Sits directly upstream of the FIR engine datapath. It consumes the `sclk`/`lrck` generated inside the engine and the raw `adc` pin, and produces the sample/valid pair the filter consumes.
- Standard I2S framing: MSB-first, one `sclk` delay after each `lrck` transition, `lrck` low = left.

## Interface
Parameters:
- `DATA_WIDTH`, default 24: sample bits captured per slot. Legal range 1..31; must be strictly less than the slot length.
- `SYNC_STAGES`, default 2: register stages applied to `sclk`, `lrck`, `adc`.

Ports:
- `clk` input 1: system clock. One clock; every other port is in this domain.
- `reset` input 1: asynchronous, active-low reset.
- `sclk` input 1: serial bit clock, generated from `clk`.
- `lrck` input 1: word select, generated from `clk`.
- `adc` input 1: raw serial data pin from the ADC.
- `sampleData` output DATA_WIDTH: two's-complement sample. Held until the next valid.
- `sampleChannel` output 1: 0 = left, 1 = right. Qualified by `sampleValid`.
- `sampleValid` output 1: one-cycle strobe marking a new sample.
- `frameError` output 1: one-cycle strobe marking a truncated slot.

## Operation
- **Input pipeline:** `sclk`, `lrck` and `adc` each pass through `SYNC_STAGES` flops so all three stay aligned.
  - `rise` = synced `sclk` high AND `sclkPrev` low. All capture logic acts only on `rise` cycles.
  - `lrckPrev` holds the synced `lrck` value at the previous `rise`.
  - `lrckEdge` = `rise` AND synced `lrck` ≠ `lrckPrev`.
- **State machine:** WAIT_SYNC, SHIFT, HOLD.
  - **WAIT_SYNC** (the reset state): ignore bits. On `lrckEdge`, latch channel = synced `lrck`, clear `bitCount`, go to SHIFT. The bit sampled on this edge is the previous slot's LSB and is discarded.
  - **SHIFT**: on a `rise` without `lrckEdge`, shift synced `adc` into the LSB of the shift register and increment `bitCount`. On the rise that captures bit number DATA_WIDTH:
    - load `sampleData` = {shift register, adc};
    - load `sampleChannel`;
    - pulse `sampleValid`;
    - go to HOLD.
  - **HOLD**: ignore the remaining slot bits. On `lrckEdge`, re-arm exactly as in WAIT_SYNC and go to SHIFT.
- **`lrckEdge` in SHIFT** (slot shorter than DATA_WIDTH):
  - pulse `frameError`;
  - discard the partial word; `sampleData` is unchanged;
  - re-arm for the new channel in the same cycle and stay in SHIFT.
- **Reset mid-operation:**
  - the whole pipeline, counters and outputs clear;
  - state returns to WAIT_SYNC;
  - no partial sample is ever emitted;
  - the first valid after reset requires a fresh `lrck` transition followed by DATA_WIDTH bits.
- **Widths:** `bitCount` is $clog2(DATA_WIDTH+1) bits and never wraps. No sign extension and no rounding.

## Timing
- **Reset values:**
  - `sampleData`, `sampleChannel`, `sampleValid`, `frameError` = 0;
  - all sync flops, `sclkPrev`, `lrckPrev` = 0;
  - state = WAIT_SYNC.
- **Latency:** `sampleValid` is high in the cycle after the edge numbered `SYNC_STAGES`+1, counting the first `clk` edge that samples raw `sclk` high (on the DATA_WIDTH-th data rise) as edge 1. With defaults, that is the cycle after edge 3.
- **Strobe width:** `sampleValid` and `frameError` are each exactly one cycle wide. They are mutually exclusive, and each fires at most once per `rise`.
- **Input constraints:**
  - `sclk` high and low phases are each at least `SYNC_STAGES`+1 `clk` cycles;
  - `lrck` and `adc` change only while `sclk` is low.
- **Throughput:** one sample per `lrck` half-period. There is no backpressure; the consumer must accept every strobe.

## Structure
- Shared package `i2s_pkg` holds:
  - the channel enum (CH_LEFT = 0, CH_RIGHT = 1);
  - the state enum {WAIT_SYNC, SHIFT, HOLD};
  - the default DATA_WIDTH and slot length (32) constants.
- One sub-module, `sync_pipe`: a parameterised N-stage, W-bit flop chain with async active-low clear, instantiated once for {sclk, lrck, adc}.

## Test plan
Bench settings: DATA_WIDTH = 24, 32-bit slots, `sclk` period 8 `clk`.

1. Reset released with all inputs idle → all outputs 0; no strobes for 1000 cycles.
2. Left word 0x800001 then right word 0x7FFFFF →
   - `sampleValid` pulses twice;
   - `sampleChannel` reads 0 then 1;
   - `sampleData` reads 0x800001 then 0x7FFFFF.
3. Release reset mid-slot, 10 bits before the first `lrck` toggle → no valid for that partial slot; the next full slot yields its correct word.
4. `lrck` toggles after only 10 data bits →
   - one `frameError` pulse and no `sampleValid`;
   - `sampleData` keeps its prior value;
   - the following full slot 0x123456 is captured correctly.
5. Assert `reset` after 12 bits of a slot →
   - outputs clear asynchronously;
   - after release, the first valid appears only after a new `lrck` edge plus 24 bits.
6. Latency check → `sampleValid` is high in the cycle after the 3rd `clk` edge, counting the first edge sampling raw `sclk` high on bit 24 as edge 1. Its width is exactly 1 cycle.

Source files
------------

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and constants for the I2S receiver.
//   ch_e      - channel tag (left = 0, right = 1, matches lrck level)
//   state_e   - receiver state machine encoding
//   I2S_DATA_WIDTH / I2S_SLOT_LEN - default sample width and slot length
package i2s_pkg;

    localparam int I2S_DATA_WIDTH = 24;
    localparam int I2S_SLOT_LEN   = 32;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } ch_e;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        SHIFT     = 2'd1,
        HOLD      = 2'd2
    } state_e;

endpackage

// File: rtl/sync_pipe.sv
// sync_pipe: STAGES-deep, W-bit flop chain with asynchronous active-low clear.
// All W bits see the same delay, so grouped signals stay aligned.
//   clk   - system clock
//   reset - asynchronous active-low clear
//   d     - W-bit input
//   q     - W-bit output, delayed STAGES clocks
module sync_pipe #(
    parameter int STAGES = 2,
    parameter int W      = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [STAGES-1:0][W-1:0] pipe_q;
    logic [STAGES-1:0][W-1:0] pipe_d;

    always_comb begin
        pipe_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign q = pipe_q[STAGES-1];

endmodule

// File: rtl/i2s_receiver.sv
// i2s_receiver: deserialises a standard I2S stream (MSB first, one sclk of
// delay after each lrck transition, lrck low = left) into parallel samples.
//   clk           - system clock; sclk/lrck are generated from it
//   reset         - asynchronous active-low reset
//   sclk, lrck    - bit clock and word select (oversampled by clk)
//   adc           - raw serial data
//   sampleData    - captured two's-complement word, held until next valid
//   sampleChannel - 0 = left, 1 = right, qualified by sampleValid
//   sampleValid   - one-cycle strobe per captured word
//   frameError    - one-cycle strobe when a slot ends before DATA_WIDTH bits
// DATA_WIDTH must be 1..31 and shorter than the slot.
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH  = I2S_DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  lrck,
    input  logic                  adc,
    output logic [DATA_WIDTH-1:0] sampleData,
    output logic                  sampleChannel,
    output logic                  sampleValid,
    output logic                  frameError
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    logic s_sclk, s_lrck, s_adc;

    // One shared chain keeps sclk, lrck and adc cycle-aligned.
    sync_pipe #(
        .STAGES (SYNC_STAGES),
        .W      (3)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     ({sclk, lrck, adc}),
        .q     ({s_sclk, s_lrck, s_adc})
    );

    logic                  sclk_prev_q, sclk_prev_d;
    logic                  lrck_prev_q, lrck_prev_d;
    state_e                state_q, state_d;
    ch_e                   ch_q, ch_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    ch_e                   out_ch_q, out_ch_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q, ferr_d;

    logic rise, lrck_edge;

    assign rise      = s_sclk & ~sclk_prev_q;
    assign lrck_edge = rise & (s_lrck != lrck_prev_q);

    always_comb begin
        sclk_prev_d = s_sclk;
        lrck_prev_d = rise ? s_lrck : lrck_prev_q;
        state_d     = state_q;
        ch_d        = ch_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        out_ch_d    = out_ch_q;
        valid_d     = 1'b0;
        ferr_d      = 1'b0;

        if (lrck_edge) begin
            // The bit on the edge rise is the previous slot's LSB: drop it and
            // re-arm for the new channel. An edge mid-word truncates the slot.
            ferr_d  = (state_q == SHIFT);
            ch_d    = ch_e'(s_lrck);
            cnt_d   = '0;
            shreg_d = '0;
            state_d = SHIFT;
        end else if (rise && state_q == SHIFT) begin
            if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                // Last bit goes straight to the output, bypassing the shifter.
                data_d   = DATA_WIDTH'({shreg_q, s_adc});
                out_ch_d = ch_q;
                valid_d  = 1'b1;
                state_d  = HOLD;
            end else begin
                shreg_d = DATA_WIDTH'({shreg_q, s_adc});
                cnt_d   = cnt_q + 1'b1;
            end
        end else if (state_q != SHIFT && state_q != HOLD && state_q != WAIT_SYNC) begin
            state_d = WAIT_SYNC;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_prev_q <= 1'b0;
            lrck_prev_q <= 1'b0;
            state_q     <= WAIT_SYNC;
            ch_q        <= CH_LEFT;
            cnt_q       <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            out_ch_q    <= CH_LEFT;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_prev_d;
            lrck_prev_q <= lrck_prev_d;
            state_q     <= state_d;
            ch_q        <= ch_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            out_ch_q    <= out_ch_d;
            valid_q     <= valid_d;
            ferr_q      <= ferr_d;
        end
    end

    assign sampleData    = data_q;
    assign sampleChannel = out_ch_q;
    assign sampleValid   = valid_q;
    assign frameError    = ferr_q;

endmodule

// File: tb/tb_i2s_receiver.sv
module tb_i2s_receiver;
    import i2s_pkg::*;

    localparam int DW   = I2S_DATA_WIDTH;
    localparam int SLOT = I2S_SLOT_LEN;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          sclk = 1'b0;
    logic          lrck = 1'b0;
    logic          adc = 1'b0;
    logic [DW-1:0] sampleData;
    logic          sampleChannel;
    logic          sampleValid;
    logic          frameError;

    i2s_receiver #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .sclk          (sclk),
        .lrck          (lrck),
        .adc           (adc),
        .sampleData    (sampleData),
        .sampleChannel (sampleChannel),
        .sampleValid   (sampleValid),
        .frameError    (frameError)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          err;
        logic        ch;
        logic [DW-1:0] data;
    } ev_t;

    ev_t got_q[$];
    int  n_val = 0;
    int  n_err = 0;
    bit  excl_bad = 0;

    // Strobe monitor, sampled just after each active edge.
    always @(posedge clk) begin
        #1;
        if (sampleValid && frameError) excl_bad = 1;
        if (sampleValid) begin
            n_val++;
            got_q.push_back('{1'b0, sampleChannel, sampleData});
        end
        if (frameError) begin
            n_err++;
            got_q.push_back('{1'b1, 1'b0, '0});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One sclk period: 4 clk low (data changes mid-low), 4 clk high.
    // With lat set, sampleValid is checked after each of the 4 high-phase edges.
    task automatic send_bit(input logic lr, input logic b, input bit lat);
        @(negedge clk) sclk = 1'b0;
        repeat (2) @(negedge clk);
        lrck = lr;
        adc  = b;
        repeat (2) @(negedge clk);
        sclk = 1'b1;
        if (lat) begin
            for (int k = 1; k <= 4; k++) begin
                @(posedge clk);
                #1;
                chk($sformatf("latency edge %0d", k), 32'(sampleValid), 32'(k == 3));
            end
        end else begin
            repeat (3) @(negedge clk);
        end
    endtask

    // Slot of len bits: first is the previous word's LSB (random), then the
    // word MSB first, then zero padding.
    task automatic send_slot(input logic lr, input logic [DW-1:0] w, input int len);
        send_bit(lr, 1'($urandom), 1'b0);
        for (int i = 1; i < len; i++) begin
            send_bit(lr, (i <= DW) ? w[DW-i] : 1'b0, 1'b0);
        end
    endtask

    typedef struct {
        logic          lr;
        logic [DW-1:0] word;
        int            len;
        int            exp_err;
        int            exp_val;
        logic          exp_ch;
        logic [DW-1:0] exp_data;
    } row_t;

    row_t rows[9];

    logic          r_lr[];
    logic [DW-1:0] r_w[];
    int            r_len[];
    ev_t           exp_q[$];

    initial begin
        int v0, e0;
        logic prev_lr;
        logic [DW-1:0] w5;

        rows[0] = '{1'b0, 24'h000000, SLOT, 0, 0, 1'b0, 24'h000000};
        rows[1] = '{1'b1, 24'hABCDEF, SLOT, 0, 1, 1'b1, 24'hABCDEF};
        rows[2] = '{1'b0, 24'h800001, SLOT, 0, 1, 1'b0, 24'h800001};
        rows[3] = '{1'b1, 24'h7FFFFF, SLOT, 0, 1, 1'b1, 24'h7FFFFF};
        rows[4] = '{1'b0, 24'h555555, 11,   0, 0, 1'b0, 24'h7FFFFF};
        rows[5] = '{1'b1, 24'h123456, SLOT, 1, 1, 1'b1, 24'h123456};
        rows[6] = '{1'b0, 24'h000000, 25,   0, 1, 1'b0, 24'h000000};
        rows[7] = '{1'b1, 24'hABCDEF, 24,   0, 0, 1'b1, 24'h000000};
        rows[8] = '{1'b0, 24'hFFFFFF, SLOT, 1, 1, 1'b0, 24'hFFFFFF};

        // Reset, then idle
        repeat (5) @(negedge clk);
        chk("reset data", 32'(sampleData), 0);
        chk("reset chan", 32'(sampleChannel), 0);
        chk("reset valid", 32'(sampleValid), 0);
        chk("reset ferr", 32'(frameError), 0);
        reset = 1'b1;
        repeat (1000) @(negedge clk);
        chk("idle strobes", 32'(n_val + n_err), 0);
        chk("idle data", 32'(sampleData), 0);

        // Table-driven slots
        for (int r = 0; r < 9; r++) begin
            v0 = n_val;
            e0 = n_err;
            send_slot(rows[r].lr, rows[r].word, rows[r].len);
            chk($sformatf("row%0d valid cnt", r), 32'(n_val - v0), 32'(rows[r].exp_val));
            chk($sformatf("row%0d ferr cnt", r), 32'(n_err - e0), 32'(rows[r].exp_err));
            chk($sformatf("row%0d data", r), 32'(sampleData), 32'(rows[r].exp_data));
            if (rows[r].exp_val != 0)
                chk($sformatf("row%0d chan", r), 32'(sampleChannel), 32'(rows[r].exp_ch));
        end

        // Reset released mid-slot, 10 bits before the lrck toggle
        @(negedge clk) reset = 1'b0;
        #1;
        chk("mid reset data clr", 32'(sampleData), 0);
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'($urandom), 1'b0);
        reset = 1'b1;
        v0 = n_val;
        e0 = n_err;
        for (int i = 0; i < 10; i++) send_bit(1'b0, 1'($urandom), 1'b0);
        chk("partial slot strobes", 32'(n_val - v0 + n_err - e0), 0);
        send_slot(1'b1, 24'h2468AC, SLOT);
        chk("post partial valid cnt", 32'(n_val - v0), 1);
        chk("post partial data", 32'(sampleData), 32'h2468AC);
        chk("post partial chan", 32'(sampleChannel), 1);

        // Reset asserted 12 bits into a slot, then latency of the next word
        for (int i = 0; i < 12; i++) send_bit(1'b0, 1'($urandom), 1'b0);
        @(negedge clk) reset = 1'b0;
        #1;
        chk("async clr data", 32'(sampleData), 0);
        chk("async clr chan", 32'(sampleChannel), 0);
        chk("async clr valid", 32'(sampleValid), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        v0 = n_val;
        e0 = n_err;
        for (int i = 12; i < SLOT; i++) send_bit(1'b0, 1'($urandom), 1'b0);
        chk("rest of slot strobes", 32'(n_val - v0 + n_err - e0), 0);
        w5 = 24'h0F0F0F;
        send_bit(1'b1, 1'b1, 1'b0);
        for (int i = 1; i < DW; i++) send_bit(1'b1, w5[DW-i], 1'b0);
        chk("no valid before bit 24", 32'(n_val - v0), 0);
        send_bit(1'b1, w5[0], 1'b1);
        chk("valid after bit 24", 32'(n_val - v0), 1);
        chk("post reset data", 32'(sampleData), 32'h0F0F0F);
        for (int i = DW + 1; i < SLOT; i++) send_bit(1'b1, 1'b0, 1'b0);

        // Randomized slots against a slot-level model
        @(negedge clk) reset = 1'b0;
        lrck = 1'b0;
        adc  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        got_q.delete();
        r_lr  = new[30];
        r_w   = new[30];
        r_len = new[30];
        r_lr[0] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 30; i++) begin
            if (i > 0) r_lr[i] = ~r_lr[i-1];
            r_w[i]   = DW'($urandom);
            r_len[i] = $urandom_range(4, 34);
        end
        // A slot is armed when its lrck differs from the one before it (0
        // after reset). Armed slots with >= DW data bits give a word; armed
        // slots cut short by the next transition give an error.
        prev_lr = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (r_lr[i] != prev_lr) begin
                if (r_len[i] - 1 >= DW) exp_q.push_back('{1'b0, r_lr[i], r_w[i]});
                else if (i < 29)        exp_q.push_back('{1'b1, 1'b0, '0});
            end
            prev_lr = r_lr[i];
        end
        for (int i = 0; i < 30; i++) send_slot(r_lr[i], r_w[i], r_len[i]);
        repeat (10) @(negedge clk);
        chk("random event count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("random ev%0d kind", i), 32'(got_q[i].err), 32'(exp_q[i].err));
            if (!exp_q[i].err) begin
                chk($sformatf("random ev%0d chan", i), 32'(got_q[i].ch), 32'(exp_q[i].ch));
                chk($sformatf("random ev%0d data", i), 32'(got_q[i].data), 32'(exp_q[i].data));
            end
        end

        chk("strobe exclusivity", 32'(excl_bad), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
